// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide unit and the
//               decoder that drives it (operation encoding, decode helper).
//               Optional feature macro: MDU_MADD_EN (multiply-accumulate ops).
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    localparam int c_DATA_W = 32;

    // True for codes that write HI/LO immediately without occupying the unit.
    function automatic logic is_move(input md_op_e op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_counter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_counter
// Description : Loadable down-counter. busy_o is high while the count is
//               non-zero; done_o marks the last busy cycle (count == 1).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load on accept, otherwise decrement until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign done_o = (cnt_q == CNT_W'(1));

endmodule : mdu_counter
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : Multi-cycle multiply/divide unit with HI/LO register pair.
//               The result is computed at accept and parked in a shadow
//               register; it is committed to HI/LO when the latency counter
//               expires. Optional feature macro: MDU_MADD_EN enables
//               MADD/MADDU/MSUB/MSUBU accumulate into {HI,LO}.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [63:0]        sh_q, sh_d;
    logic               skip_q, skip_d;

    md_op_e             w_op;
    logic               w_accept;
    logic               w_is_comp;
    logic               w_div0;
    logic               w_done;
    logic [c_CNT_W-1:0] w_lat;
    logic [63:0]        w_res;
    logic [63:0]        w_smul;
    logic [63:0]        w_umul;
    logic [31:0]        w_bs_safe;
    logic [31:0]        w_bu_safe;
    logic [31:0]        w_sq, w_sr, w_uq, w_ur;
    logic               w_b_zero;
    logic               w_div_ovf;

    assign w_op     = md_op_e'(md_op);
    assign w_accept = start && !busy;

    // Arithmetic datapath. A zero divisor is replaced by 1 so the dividers
    // never see it (the result is discarded anyway); the signed overflow case
    // 0x80000000 / -1 is also divided by 1, which yields the required
    // quotient 0x80000000 and remainder 0 without relying on overflow wrap.
    assign w_b_zero  = (src_b == 32'd0);
    assign w_div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    assign w_bs_safe = (w_b_zero || w_div_ovf) ? 32'd1 : src_b;
    assign w_bu_safe = w_b_zero ? 32'd1 : src_b;
    assign w_sq      = $signed(src_a) / $signed(w_bs_safe);
    assign w_sr      = $signed(src_a) % $signed(w_bs_safe);
    assign w_uq      = src_a / w_bu_safe;
    assign w_ur      = src_a % w_bu_safe;
    assign w_smul    = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign w_umul    = {32'd0, src_a} * {32'd0, src_b};

    // Decode: classify the op, pick its latency and its 64-bit shadow value.
    always_comb begin
        w_is_comp = 1'b0;
        w_div0    = 1'b0;
        w_lat     = '0;
        w_res     = '0;
        case (w_op)
            MD_MULT: begin
                w_is_comp = 1'b1;
                w_lat     = c_CNT_W'(MULT_LAT);
                w_res     = w_smul;
            end
            MD_MULTU: begin
                w_is_comp = 1'b1;
                w_lat     = c_CNT_W'(MULT_LAT);
                w_res     = w_umul;
            end
            MD_DIV: begin
                w_is_comp = 1'b1;
                w_lat     = c_CNT_W'(DIV_LAT);
                w_div0    = w_b_zero;
                w_res     = {w_sr, w_sq};
            end
            MD_DIVU: begin
                w_is_comp = 1'b1;
                w_lat     = c_CNT_W'(DIV_LAT);
                w_div0    = w_b_zero;
                w_res     = {w_ur, w_uq};
            end
`ifdef MDU_MADD_EN
            MD_MADD: begin
                w_is_comp = 1'b1;
                w_lat     = c_CNT_W'(MULT_LAT);
                w_res     = {hi_q, lo_q} + w_smul;
            end
            MD_MADDU: begin
                w_is_comp = 1'b1;
                w_lat     = c_CNT_W'(MULT_LAT);
                w_res     = {hi_q, lo_q} + w_umul;
            end
            MD_MSUB: begin
                w_is_comp = 1'b1;
                w_lat     = c_CNT_W'(MULT_LAT);
                w_res     = {hi_q, lo_q} - w_smul;
            end
            MD_MSUBU: begin
                w_is_comp = 1'b1;
                w_lat     = c_CNT_W'(MULT_LAT);
                w_res     = {hi_q, lo_q} - w_umul;
            end
`endif
            default: begin
                w_is_comp = 1'b0;
            end
        endcase
    end

    mdu_counter #(
        .CNT_W (c_CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_accept && w_is_comp),
        .load_val_i (w_lat),
        .busy_o     (busy),
        .done_o     (w_done)
    );

    // HI/LO and shadow next state: commit on done (unless divide-by-zero),
    // direct moves and shadow capture on accept. Accept and done never
    // coincide because accept requires the counter to be idle.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        sh_d   = sh_q;
        skip_d = skip_q;
        if (w_done && !skip_q) begin
            hi_d = sh_q[63:32];
            lo_d = sh_q[31:0];
        end
        if (w_accept) begin
            if (is_move(w_op)) begin
                if (w_op == MD_MTHI) begin
                    hi_d = src_a;
                end else begin
                    lo_d = src_a;
                end
            end else if (w_is_comp) begin
                sh_d   = w_res;
                skip_d = w_div0;
            end
        end
    end

    // HI/LO and shadow registers; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            sh_q   <= '0;
            skip_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            sh_q   <= sh_d;
            skip_q <= skip_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule : mdu_unit
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_unit
// Description : Directed self-checking bench for mdu_unit (MULT_LAT=5,
//               DIV_LAT=10). Expected values are hand-computed constants.
//               Honours MDU_MADD_EN for the accumulate step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_bad;

    mdu_unit #(
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hazard-unit contract: start must never be presented while busy.
    always @(negedge clk) begin
        if (!reset && start && busy) begin
            n_cmp++;
            n_bad++;
            $error("FAIL hazard_contract start=%0b busy=%0b required busy=0", start, busy);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents a one-cycle start; returns at the negedge of cycle T0+1.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        src_a = '0;
        src_b = '0;
    endtask

    // Counts busy cycles from T0+1 onward, bounded.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    int bc;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        md_op = MD_NONE;
        src_a = '0;
        src_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);

        // mult -2 * 3
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_no_bypass_lo", lo, 32'h0);
        count_busy(bc);
        check("mult_busy_cycles", bc, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // multu 0xFFFFFFFE * 3
        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        count_busy(bc);
        check("multu_busy_cycles", bc, 32'd5);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        // div -7 / 2
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(bc);
        check("div_busy_cycles", bc, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // div overflow 0x80000000 / -1
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(bc);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);

        // divu 100 / 7
        issue(MD_DIVU, 32'd100, 32'd7);
        count_busy(bc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // mthi / mtlo preload, no busy
        issue(MD_MTHI, 32'h11, 32'h0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h11);
        issue(MD_MTLO, 32'h22, 32'h0);
        check("mtlo_lo", lo, 32'h22);

        // divu by zero leaves HI/LO unchanged after full latency
        issue(MD_DIVU, 32'd7, 32'd0);
        count_busy(bc);
        check("divz_busy_cycles", bc, 32'd10);
        check("divz_hi", hi, 32'h11);
        check("divz_lo", lo, 32'h22);

        // NONE and undefined code are ignored
        issue(MD_NONE, 32'h1234, 32'h5678);
        check("none_busy", {31'd0, busy}, 32'd0);
        issue(4'd13, 32'h1234, 32'h5678);
        check("undef_busy", {31'd0, busy}, 32'd0);
        check("undef_hi", hi, 32'h11);
        check("undef_lo", lo, 32'h22);

        // mult 6x7 aborted by reset during cycle T0+3
        issue(MD_MULT, 32'd6, 32'd7);   // now in T0+1
        @(negedge clk);                 // T0+2
        @(negedge clk);                 // T0+3
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);                 // T0+4
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        repeat (4) @(negedge clk);
        check("abort_no_late_hi", hi, 32'h0);
        check("abort_no_late_lo", lo, 32'h0);

        // Accumulate: mthi 0, mtlo 10, madd 3x4
        issue(MD_MTHI, 32'd0, 32'd0);
        issue(MD_MTLO, 32'd10, 32'd0);
        issue(MD_MADD, 32'd3, 32'd4);
        count_busy(bc);
`ifdef MDU_MADD_EN
        check("madd_busy_cycles", bc, 32'd5);
        check("madd_lo", lo, 32'd22);
        check("madd_hi", hi, 32'd0);
`else
        check("madd_off_busy_cycles", bc, 32'd0);
        check("madd_off_lo", lo, 32'd10);
        check("madd_off_hi", hi, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mdu_unit
`default_nettype wire

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit with the HI/LO register pair, in the E stage of the 5-stage MIPS32 pipeline.
- Sits directly downstream of the forwarding mux and consumes its forwarded E-stage operands Src1/Src2.
- Exports busy/start status to the hazard unit, which stalls D-stage mult/div/mfhi/mflo/mthi/mtlo while an operation is in flight.
- HI/LO read-out feeds the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_LAT, 5, cycles busy is held for mult/multu (and madd family when enabled); must be >=1
- DIV_LAT, 10, cycles busy is held for div/divu; must be >=1

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; qualified by md_op; E-stage instr valid and not bubbled
- md_op  input  4  operation code (package enum)
- src_a  input  32  forwarded rs value (Src1)
- src_b  input  32  forwarded rt value (Src2)
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: hi=0, lo=0, busy=0, counter=0, shadow result discarded. Applies mid-operation: the pending result is dropped and HI/LO are cleared.
- Accept: at edge T0 with start=1 and busy=0.
  - mthi: hi<=src_a at T0. No busy.
  - mtlo: lo<=src_a at T0. No busy.
  - Compute op: latch the 64-bit result into shadow {sh_hi, sh_lo}; counter<=LAT (MULT_LAT or DIV_LAT); busy=1.
- Busy window: busy is high in cycles T0+1 .. T0+LAT inclusive; the counter decrements each edge.
- Completion: at the edge ending cycle T0+LAT, hi/lo<=shadow and busy<=0. New HI/LO are visible from T0+LAT+1.
- Start while busy=1: ignored, no state change. This is a hazard-unit contract violation; the bench flags it with an assertion.
- start=1 with md_op NONE or an undefined code: ignored.
- Arithmetic:
  - mult: signed 32x32->64. hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32->64.
  - div: lo=quotient truncated toward zero; hi=remainder carrying the dividend's sign.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (src_b=0): busy still runs the full DIV_LAT; hi/lo left unchanged at completion.
- hi/lo outputs are plain registers; no bypass of in-flight results. The hazard unit guarantees mf* waits while busy|start.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: md_op also accepts MADD, MADDU, MSUB, MSUBU.
  - Shadow = {hi,lo} +/- product, using the HI/LO values at accept edge T0.
  - Signed or unsigned product per op; 64-bit wrap-around, no saturation.
  - Latency MULT_LAT.
- Undefined: these codes are treated as undefined and ignored. No extra adder logic is synthesised.

Decomposition:
- Shared package mdu_pkg: md_op enum with NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
- The controller's decoder uses the same package.
- Sub-module mdu_counter: loadable down-counter producing busy and done pulses, reused for both latencies.

Test Plan:
- mult, a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu, same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
- div, a=-7, b=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu, a=7, b=0 with hi/lo preloaded via mthi 0x11 / mtlo 0x22 -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- mult 6x7 started, reset asserted at cycle T0+3 -> busy=0, hi=lo=0 next cycle; no late write at T0+5.
- MDU_MADD_EN: mtlo 10, then madd 3x4 -> lo=22, hi=0. Same stimulus without macro -> lo=10 unchanged, busy never rises.
